// File: rtl/noc_host_pkg.sv
// Shared definitions for the NoC host-port scheduler.
// Holds data/control widths, control-word field positions, the scheduler
// state type, response error codes and a destination range check.
package noc_host_pkg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;

  // control word layout: [3:0] opcode, [7:4] dst_x, [11:8] dst_y, [15:12] reserved
  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 4;
  localparam int DSTX_LSB = 4;
  localparam int DSTX_W   = 4;
  localparam int DSTY_LSB = 8;
  localparam int DSTY_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INJECT = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DEST    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic dst_in_grid(input logic [CTRL_W-1:0] ctrl,
                                       input int gx, input int gy);
    return (int'(ctrl[DSTX_LSB +: DSTX_W]) < gx) &&
           (int'(ctrl[DSTY_LSB +: DSTY_W]) < gy);
  endfunction

endpackage

// File: rtl/noc_host_scheduler_if.sv
// Requester-side bus of the NoC host scheduler.
// master: requester side (drives requests and response accepts)
// slave : scheduler side (drives acceptance pulses and responses)
// Signals: req_valid/req_ready, packed req_a/req_b/req_ctrl,
//          rsp_valid/rsp_ready, shared rsp_data/rsp_err.
interface noc_host_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]                      req_valid;
  logic [NUM_REQ-1:0]                      req_ready;
  logic [NUM_REQ*noc_host_pkg::DATA_W-1:0] req_a;
  logic [NUM_REQ*noc_host_pkg::DATA_W-1:0] req_b;
  logic [NUM_REQ*noc_host_pkg::CTRL_W-1:0] req_ctrl;
  logic [NUM_REQ-1:0]                      rsp_valid;
  logic [NUM_REQ-1:0]                      rsp_ready;
  logic [noc_host_pkg::DATA_W-1:0]         rsp_data;
  logic [1:0]                              rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: grants the first set req_i bit at or after ptr_i,
// wrapping. Nothing is granted while advance_i is low.
// Ports: req_i (requests), ptr_i (search start), advance_i (enable),
//        grant_o (one-hot), idx_o (index of the granted bit).
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             advance_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      // one extra bit so ptr+k can exceed N-1 before the wrap
      cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (advance_i && !found && req_i[cand[IDX_W-1:0]]) begin
        found                      = 1'b1;
        idx_o                      = cand[IDX_W-1:0];
        grant_o[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_host_scheduler.sv
// Admission controller for the host port of tile (0,0). Admits one request
// at a time (round-robin), injects a single flit, waits for the result or a
// timeout, and returns it to the granted requester.
// Ports: clk, rst (sync, active-high); req_if (requester bus, slave side);
//        host_in_* to the tile, host_out_* from the tile;
//        busy, timeout_cnt, spurious_cnt status.
//
// state     | meaning
// ST_IDLE   | arbitrate; capture operands of the granted requester
// ST_INJECT | host_in_valid high for one cycle
// ST_WAIT   | wait for host_out_valid or timer terminal count
// ST_RESP   | present response until the granted requester accepts
module noc_host_scheduler
  import noc_host_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GRID_X         = 3,
  parameter int GRID_Y         = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  noc_host_scheduler_if.slave req_if,
  output logic [DATA_W-1:0]  host_in_a,
  output logic [DATA_W-1:0]  host_in_b,
  output logic [CTRL_W-1:0]  host_in_ctrl,
  output logic               host_in_valid,
  input  logic [DATA_W-1:0]  host_out_a,
  input  logic               host_out_valid,
  output logic               busy,
  output logic [15:0]        timeout_cnt,
  output logic [15:0]        spurious_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, data_q, data_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [1:0]         err_q, err_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [15:0]        tcnt_q, tcnt_d, scnt_q, scnt_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic [CTRL_W-1:0]  sel_ctrl;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i     (req_if.req_valid),
    .ptr_i     (ptr_q),
    .advance_i (state_q == ST_IDLE && !rst),
    .grant_o   (arb_grant),
    .idx_o     (arb_idx)
  );

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_a    = req_if.req_a[i*DATA_W +: DATA_W];
        sel_b    = req_if.req_b[i*DATA_W +: DATA_W];
        sel_ctrl = req_if.req_ctrl[i*CTRL_W +: CTRL_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    err_d   = err_q;
    tmr_d   = tmr_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;

    if (host_out_valid && state_q != ST_WAIT && scnt_q != 16'hFFFF)
      scnt_d = scnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          gidx_d = arb_idx;
          a_d    = sel_a;
          b_d    = sel_b;
          ctrl_d = sel_ctrl;
          ptr_d  = (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
          if (dst_in_grid(sel_ctrl, GRID_X, GRID_Y)) begin
            state_d = ST_INJECT;
          end else begin
            data_d  = '0;
            err_d   = ERR_DEST;
            state_d = ST_RESP;
          end
        end
      end
      ST_INJECT: begin
        // down-counter: WAIT lasts at most TIMEOUT_CYCLES cycles
        tmr_d   = TMR_W'(TIMEOUT_CYCLES - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // a result on the terminal-count cycle takes priority over timeout
        if (host_out_valid) begin
          data_d  = host_out_a;
          err_d   = ERR_OK;
          state_d = ST_RESP;
        end else if (tmr_q == '0) begin
          data_d  = '0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (req_if.rsp_ready[gidx_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
      err_q   <= ERR_OK;
      tmr_q   <= '0;
      tcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  logic flit_live;
  assign flit_live = (state_q == ST_INJECT) || (state_q == ST_WAIT);

  assign req_if.req_ready = arb_grant;
  assign req_if.rsp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << gidx_q) : '0;
  assign req_if.rsp_data  = (state_q == ST_RESP) ? data_q : '0;
  assign req_if.rsp_err   = (state_q == ST_RESP) ? err_q : ERR_OK;

  assign host_in_a     = flit_live ? a_q : '0;
  assign host_in_b     = flit_live ? b_q : '0;
  assign host_in_ctrl  = flit_live ? ctrl_q : '0;
  assign host_in_valid = (state_q == ST_INJECT);

  assign busy         = (state_q != ST_IDLE);
  assign timeout_cnt  = tcnt_q;
  assign spurious_cnt = scnt_q;

endmodule

// File: tb/tb_noc_host_scheduler.sv
// Self-checking bench for noc_host_scheduler: directed scenarios followed by
// randomized transactions, compared against a transaction-level model.
module tb_noc_host_scheduler;
  import noc_host_pkg::*;

  localparam int NREQ = 4;
  localparam int TMO  = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_host_scheduler_if #(.NUM_REQ(NREQ)) rif ();

  logic [63:0] host_in_a, host_in_b, host_out_a;
  logic [15:0] host_in_ctrl, timeout_cnt, spurious_cnt;
  logic        host_in_valid, host_out_valid, busy;

  noc_host_scheduler #(
    .NUM_REQ(NREQ), .GRID_X(3), .GRID_Y(3), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_if(rif),
    .host_in_a(host_in_a), .host_in_b(host_in_b), .host_in_ctrl(host_in_ctrl),
    .host_in_valid(host_in_valid), .host_out_a(host_out_a),
    .host_out_valid(host_out_valid), .busy(busy),
    .timeout_cnt(timeout_cnt), .spurious_cnt(spurious_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;
  int m_tcnt  = 0;
  int m_scnt  = 0;

  logic [63:0] op_a [NREQ];
  logic [63:0] op_b [NREQ];
  logic [15:0] op_c [NREQ];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) begin
      rif.req_a[i*64 +: 64]    = op_a[i];
      rif.req_b[i*64 +: 64]    = op_b[i];
      rif.req_ctrl[i*16 +: 16] = op_c[i];
    end
  endtask

  task automatic rand_op(input int i, input bit force_good);
    logic [3:0] x, y;
    op_a[i] = {$urandom, $urandom};
    op_b[i] = {$urandom, $urandom};
    x = (!force_good && $urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
    y = (!force_good && $urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
    op_c[i] = {4'($urandom), y, x, 4'($urandom)};
  endtask

  // lat: WAIT cycle (0-based) on which the tile answers; -1 = never.
  task automatic run_txn(input logic [NREQ-1:0] mask, input int lat, input int bp,
                         input bit spur, input bit idle_spur, output int g_obs);
    int g, k, wcnt;
    bit bad, hit;
    logic [63:0] res, exp_data;
    logic [1:0]  exp_err;
    logic [NREQ-1:0] rr;

    g = -1;
    for (int i = 0; i < NREQ; i++) begin
      k = (m_ptr + i) % NREQ;
      if (g < 0 && mask[k]) g = k;
    end
    rif.req_valid = mask;
    #1;
    wcnt = 0;
    while (rif.req_ready == '0 && wcnt < 8) begin
      step();
      host_out_valid = 1'b0;
      #1;
      wcnt++;
    end
    g_obs = -1;
    for (int i = 0; i < NREQ; i++) if (rif.req_ready[i]) g_obs = i;
    chk("grant", 64'(rif.req_ready), 64'(1) << g);
    m_ptr = (g + 1) % NREQ;

    bad = (int'(op_c[g][7:4]) >= 3) || (int'(op_c[g][11:8]) >= 3);
    res = op_a[g] + op_b[g];
    hit = !bad && lat >= 0 && lat < TMO;
    if (bad) begin
      exp_data = '0; exp_err = 2'd1;
    end else if (hit) begin
      exp_data = res; exp_err = 2'd0;
    end else begin
      exp_data = '0; exp_err = 2'd2;
      m_tcnt++;
    end

    if (!bad) begin
      step();
      rif.req_valid  = '0;
      host_out_valid = 1'b0;
      #1;
      chk("inject_valid", 64'(host_in_valid), 64'(1));
      chk("inject_a", host_in_a, op_a[g]);
      chk("inject_b", host_in_b, op_b[g]);
      chk("inject_ctrl", 64'(host_in_ctrl), 64'(op_c[g]));
      for (int c = 0; c < TMO; c++) begin
        step();
        host_out_valid = (c == lat);
        host_out_a     = (c == lat) ? res : {$urandom, $urandom};
        #1;
        chk("wait_no_rsp", 64'(rif.rsp_valid), 64'(0));
        chk("wait_hold_a", host_in_a, op_a[g]);
        chk("wait_single_inject", 64'(host_in_valid), 64'(0));
        if (c == lat) break;
      end
    end

    for (int b = 0; b <= bp; b++) begin
      step();
      rr = NREQ'($urandom);
      rr[g] = (b == bp);
      rif.rsp_ready  = rr;
      rif.req_valid  = NREQ'($urandom);
      host_out_valid = spur && b[0];
      host_out_a     = {$urandom, $urandom};
      if (host_out_valid) m_scnt++;
      #1;
      chk("rsp_valid", 64'(rif.rsp_valid), 64'(1) << g);
      chk("rsp_data", rif.rsp_data, exp_data);
      chk("rsp_err", 64'(rif.rsp_err), 64'(exp_err));
      chk("rsp_no_grant", 64'(rif.req_ready), 64'(0));
      chk("rsp_no_inject", 64'(host_in_valid), 64'(0));
    end

    step();
    rif.req_valid  = '0;
    rif.rsp_ready  = '0;
    host_out_valid = idle_spur;
    #1;
    chk("idle_rsp_valid", 64'(rif.rsp_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_host_a", host_in_a, 64'(0));
    chk("timeout_cnt", 64'(timeout_cnt), 64'(m_tcnt));
    chk("spurious_cnt", 64'(spurious_cnt), 64'(m_scnt));
    if (idle_spur) m_scnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int rr_seq [5] = '{0, 1, 2, 3, 0};
    int lat;

    rst = 1'b1;
    rif.req_valid = '0; rif.rsp_ready = '0;
    rif.req_a = '0; rif.req_b = '0; rif.req_ctrl = '0;
    host_out_a = '0; host_out_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) rand_op(i, 1'b1);
    load_ops();
    step(); step(); step();
    rst = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_inject", 64'(host_in_valid), 64'(0));
    chk("reset_rsp_valid", 64'(rif.rsp_valid), 64'(0));
    chk("reset_tcnt", 64'(timeout_cnt), 64'(0));
    chk("reset_scnt", 64'(spurious_cnt), 64'(0));

    // single OK: 5 + 7, tile answers three cycles after INJECT
    op_a[0] = 64'd5; op_b[0] = 64'd7; op_c[0] = 16'h0000;
    load_ops();
    run_txn(4'b0001, 2, 0, 1'b0, 1'b0, g);

    // bad destination dst_x = 3
    op_c[2] = 16'h0031;
    load_ops();
    run_txn(4'b0100, 0, 1, 1'b0, 1'b0, g);

    // timeout, then answer on the terminal cycle
    rand_op(3, 1'b1); load_ops();
    run_txn(4'b1000, -1, 0, 1'b0, 1'b0, g);
    chk("timeout_cnt_one", 64'(timeout_cnt), 64'(1));
    rand_op(0, 1'b1); load_ops();
    run_txn(4'b0001, TMO - 1, 0, 1'b0, 1'b0, g);

    // backpressure with spurious pulses
    rand_op(1, 1'b1); load_ops();
    run_txn(4'b0010, 4, 10, 1'b1, 1'b1, g);

    // reset in the middle of WAIT
    rand_op(2, 1'b1); load_ops();
    rif.req_valid = 4'b0100;
    #1;
    chk("rst_pre_grant", 64'(rif.req_ready), 64'(4'b0100));
    step(); rif.req_valid = '0; host_out_valid = 1'b0; #1;
    chk("rst_pre_inject", 64'(host_in_valid), 64'(1));
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rsp_valid", 64'(rif.rsp_valid), 64'(0));
    chk("rst_rsp_data", rif.rsp_data, 64'(0));
    chk("rst_req_ready", 64'(rif.req_ready), 64'(0));
    chk("rst_host_valid", 64'(host_in_valid), 64'(0));
    chk("rst_host_a", host_in_a, 64'(0));
    chk("rst_tcnt", 64'(timeout_cnt), 64'(0));
    chk("rst_scnt", 64'(spurious_cnt), 64'(0));
    m_ptr = 0; m_tcnt = 0; m_scnt = 0;

    // round-robin with every requester asking
    for (int i = 0; i < NREQ; i++) rand_op(i, 1'b1);
    load_ops();
    for (int t = 0; t < 5; t++) begin
      run_txn(4'b1111, 1, 0, 1'b0, 1'b0, g);
      chk("rr_order", 64'(g), 64'(rr_seq[t]));
    end

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) rand_op(i, 1'b0);
      load_ops();
      case ($urandom_range(0, 9))
        0:       lat = -1;
        1:       lat = TMO - 1;
        default: lat = $urandom_range(0, 6);
      endcase
      run_txn(NREQ'($urandom_range(1, 15)), lat, $urandom_range(0, 3),
              1'($urandom), ($urandom_range(0, 3) == 0), g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_host_scheduler.md
Name: noc_host_scheduler

Overview:
- Admission controller in front of the host port of tile (0,0) of the 3x3 ALU NoC.
- The mesh carries only one packet at a time, so this block arbitrates NUM_REQ requesters round-robin and injects exactly one flit.
- It then waits for host_out_valid, or a timeout, and returns the result to the granted requester before admitting the next one.
- It replaces the ad-hoc "calculator waits for valid" sequencing at top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- GRID_X, 3, mesh width; destinations with x >= GRID_X are rejected
- GRID_Y, 3, mesh height; destinations with y >= GRID_Y are rejected
- TIMEOUT_CYCLES, 64, cycles in WAIT before declaring the packet lost (>= 2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- req_a  in  NUM_REQ*64  operand A, requester i at [64*i +: 64]
- req_b  in  NUM_REQ*64  operand B, same packing as req_a
- req_ctrl  in  NUM_REQ*16  control word: [3:0] opcode, [7:4] dst_x, [11:8] dst_y, [15:12] reserved (forwarded unchanged)
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  64  result (shared bus, meaningful only while any rsp_valid is high)
- rsp_err  out  2  0 = OK, 1 = bad destination, 2 = timeout
- host_in_a  out  64  to tile (0,0) host_in_a
- host_in_b  out  64  to tile (0,0) host_in_b
- host_in_ctrl  out  16  to tile (0,0) host_in_ctrl
- host_in_valid  out  1  to tile (0,0) host_in_valid
- host_out_a  in  64  from tile (0,0)
- host_out_valid  in  1  from tile (0,0)
- busy  out  1  high in every state except IDLE
- timeout_cnt  out  16  saturating count of timeouts
- spurious_cnt  out  16  saturating count of host_out_valid seen outside WAIT

Behaviour:
- Reset (synchronous, highest priority):
  - All outputs 0, FSM to IDLE, round-robin pointer to 0, counters to 0.
  - Any in-flight packet is dropped; no response is issued for it.
- States: IDLE, INJECT, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after rr_ptr, wrapping.
  - In the same cycle: pulse req_ready[g] for 1 cycle; capture a, b, ctrl and g; set rr_ptr = (g+1) mod NUM_REQ.
  - If dst_x >= GRID_X or dst_y >= GRID_Y: go to RESP with err=1 and rsp_data=0. Nothing is injected.
  - Otherwise go to INJECT.
- INJECT:
  - host_in_valid=1 for exactly this one cycle, then go to WAIT.
  - host_in_a/b/ctrl show the captured values from INJECT through the end of WAIT, then return to 0.
- WAIT:
  - A cycle counter starts at 0 on entry.
  - host_out_valid=1: capture host_out_a, set err=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no valid: err=2, rsp_data=0, timeout_cnt += 1 (saturating), go to RESP.
  - Valid arriving in the same cycle as the terminal count: the result wins (err=0).
- RESP:
  - rsp_valid[g]=1; rsp_data and rsp_err are held stable until rsp_ready[g].
  - On acceptance go to IDLE next cycle, so the minimum gap between grants is 1 IDLE cycle.
  - rsp_ready on other bits is ignored.
- host_out_valid in IDLE, INJECT or RESP: ignored, spurious_cnt += 1 (saturating).
- req_valid deasserted by a requester before its grant: no effect. Arbitration uses only the current cycle's req_valid.
- Latency (OK case):
  - The grant cycle and INJECT take 1 cycle each.
  - WAIT lasts hop-latency cycles.
  - rsp_valid rises the cycle after host_out_valid.
- Only one transaction is outstanding at any time, which guarantees the mesh's single-packet invariant.

Decomposition:
- Package noc_host_pkg holds:
  - widths: DATA_W=64, CTRL_W=16
  - ctrl field offsets and widths: opcode, dst_x, dst_y
  - state enum
  - rsp_err codes: ERR_OK, ERR_DEST, ERR_TIMEOUT
- One sub-module, rr_arbiter: parameter N, with inputs req[N], ptr and advance, and outputs a one-hot grant and its index.
- The FSM, timeout counter and status counters stay in noc_host_scheduler.

Test Plan:
- Single OK transaction:
  - Stimulus: requester 0 sends a=5, b=7, ctrl dst=(0,0) add; the tile model returns 12 three cycles after INJECT.
  - Required: req_ready[0] pulse, one-cycle host_in_valid, rsp_valid[0] with rsp_data=12, err=0.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held, rsp_ready tied high.
  - Required: grants in order 0,1,2,3,0; no requester is granted twice before all others are served.
- Bad destination:
  - Stimulus: ctrl dst_x=3 (GRID_X=3).
  - Required: host_in_valid is never asserted; rsp_err=1, rsp_data=0.
- Timeout:
  - Stimulus: the tile never responds.
  - Required: rsp_err=2 exactly TIMEOUT_CYCLES cycles after WAIT entry; timeout_cnt=1.
  - Variant: host_out_valid on the terminal cycle must produce err=0.
- Backpressure and spurious valid:
  - Stimulus: hold rsp_ready[1]=0 for 10 cycles while pulsing host_out_valid.
  - Required: rsp_data stays stable, spurious_cnt increments, no new grant occurs.
- Reset mid-WAIT:
  - Stimulus: assert rst for 1 cycle during WAIT.
  - Required: all outputs 0 the next cycle, no rsp_valid, rr_ptr=0; the next request is granted normally.
